pipe_latch_chain: RTL and testbench
===================================

Name: pipe_latch_chain

Overview:
- Parametrised successor to the fixed-width inter-stage pipeline register used between CPU stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Is a chain of DEPTH registered stages, each WIDTH bits wide, with a valid bit per stage and ready/valid backpressure.
- Empty stages (bubbles) collapse, so items advance into them even while the output is stalled.
- Adds global flush, synchronous reset and an occupancy count; replaces ad-hoc stall/flush muxing around plain registers.

Parameters:
- WIDTH, 32: data bits per stage.
- DEPTH, 2: number of register stages; legal range is 1 or more.
- BUBBLE, 0 (WIDTH bits): data value held by any stage that is invalid.

Ports:
- clk_i, in, 1: clock; all state updates on the rising edge.
- rst_i, in, 1: reset, synchronous and active-high.
- flush_i, in, 1: synchronous clear of all stages (squash for a taken branch or jump).
- in_valid_i, in, 1: upstream offers in_data_i.
- in_data_i, in, WIDTH: upstream payload.
- in_ready_o, out, 1: chain accepts an item this cycle.
- out_valid_o, out, 1: last stage holds a valid item.
- out_data_o, out, WIDTH: last-stage payload; equals BUBBLE when out_valid_o=0.
- out_ready_i, in, 1: downstream consumes the item this cycle.
- count_o, out, $clog2(DEPTH+1): number of valid stages.

Behaviour:
- Stage numbering: stage 0 is the input side, stage DEPTH-1 drives the outputs. State per stage k is v[k] and d[k].
- Enable chain (combinational):
  - en[DEPTH-1] = !v[DEPTH-1] | out_ready_i
  - en[k] = !v[k] | en[k+1]
  - in_ready_o = en[0]
  - in_ready_o may depend combinationally on out_ready_i; no registered-ready variant exists.
- Transfer rules:
  - Accept occurs when in_valid_i & in_ready_o. Consume occurs when out_valid_o & out_ready_i.
  - On an edge with en[k]=1, stage k loads from its source: in_* for k=0, stage k-1 otherwise.
  - If the source is invalid, stage k loads v=0 and d=BUBBLE.
  - A stage with en[k]=0 holds its v and d.
- Latency and throughput:
  - An item accepted in cycle c is visible on out_* in cycle c+DEPTH when no backpressure applies.
  - Throughput is 1 item per cycle; no bubbles are inserted when full and out_ready_i=1.
- Backpressure:
  - With out_ready_i=0, items advance into any empty downstream stage.
  - in_ready_o drops only when all DEPTH stages are valid.
- Full chain with out_ready_i=1: the output item is consumed, every stage shifts, and a new item is accepted in the same cycle (simultaneous accept and consume).
- Empty chain: out_valid_o=0, out_data_o=BUBBLE, count_o=0, in_ready_o=1.
- Flush (flush_i=1):
  - On the edge, all v are cleared and all d are set to BUBBLE.
  - Any concurrent accept is dropped; in_ready_o may still read 1.
  - Any concurrent consume still counts for the downstream side, i.e. the output was presented valid that cycle.
  - Flush has priority over every transfer.
- Reset (rst_i=1): identical state effect to flush.
  - Outputs after the reset edge: out_valid_o=0, out_data_o=BUBBLE, count_o=0, in_ready_o=1.
  - Reset mid-stream discards all in-flight items with no partial output.
  - Reset has priority over flush.
- count_o:
  - Registered popcount of v, updated each edge.
  - Equals the previous value + accept − consume, except on flush/reset, where it becomes 0.
- Output stability: out_data_o must not change while out_valid_o=1 and out_ready_i=0.
- DEPTH=1: the block degenerates to a single valid-tagged register with in_ready_o = !v[0] | out_ready_i.

Test Plan:
1. DEPTH=3, WIDTH=8, out_ready_i=1; stream 0x11, 0x22, 0x33 in cycles 0..2 → out_valid_o with 0x11, 0x22, 0x33 in cycles 3, 4, 5; in_ready_o=1 throughout; count_o peaks at 3.
2. DEPTH=3, out_ready_i=0; offer A, B, C, D in cycles 0..3 → A, B, C accepted; cycle 3 in_ready_o=0, count_o=3, out_data_o=A held stable. Raise out_ready_i in cycle 4 → A consumed and D accepted in the same cycle; count_o stays 3.
3. DEPTH=3; accept item X in cycle 0, then in_valid_i=0, with out_ready_i=0 → X reaches the output in cycle 3 (bubbles collapsed); stages 0 and 1 read invalid; count_o=1.
4. Full chain plus flush_i=1 with in_valid_i=1 → next cycle out_valid_o=0, out_data_o=BUBBLE, count_o=0; the offered item never appears at the output.
5. Mid-stream rst_i=1 with flush_i=1 and in_valid_i=1 all asserted together → all outputs at reset values the next cycle; a later accepted item emerges after exactly DEPTH cycles.
6. DEPTH=1, WIDTH=32; alternate out_ready_i 1/0 with continuous input 0xDEADBEEF+n → no item lost or duplicated; in_ready_o = !out_valid_o | out_ready_i every cycle.

Source files
------------

// File: rtl/pipe_latch_chain.sv
// pipe_latch_chain: parametrised inter-stage pipeline register chain.
// DEPTH registered stages of WIDTH bits, each tagged with a valid bit, with
// ready/valid backpressure. Empty stages collapse so items keep advancing
// while the output is stalled. Flush and reset clear every stage.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        synchronous active-high reset (priority over flush)
//   flush_i      synchronous clear of all stages
//   in_valid_i   upstream offers in_data_i
//   in_data_i    upstream payload
//   in_ready_o   chain accepts an item this cycle (combinational)
//   out_valid_o  last stage holds a valid item
//   out_data_o   last-stage payload, BUBBLE when invalid
//   out_ready_i  downstream consumes the item this cycle
//   count_o      registered number of valid stages
module pipe_latch_chain #(
   parameter int unsigned       WIDTH  = 32,
   parameter int unsigned       DEPTH  = 2,
   parameter logic [WIDTH-1:0]  BUBBLE = '0
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         flush_i,
   input  logic                         in_valid_i,
   input  logic [WIDTH-1:0]             in_data_i,
   output logic                         in_ready_o,
   output logic                         out_valid_o,
   output logic [WIDTH-1:0]             out_data_o,
   input  logic                         out_ready_i,
   output logic [$clog2(DEPTH+1)-1:0]   count_o
);

   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [DEPTH-1:0] v;
   logic [WIDTH-1:0] d [DEPTH];
   logic [DEPTH-1:0] en;
   logic [CW-1:0]    count;
   logic             accept;
   logic             consume;

   // Stage k may load when it or any stage downstream of it has a free slot,
   // or the output is being consumed. Walked from the output side inward.
   always_comb begin
      logic stall;
      stall = !out_ready_i;
      en    = '0;
      for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
         stall = stall & v[k];
         en[k] = !stall;
      end
   end

   assign in_ready_o = en[0];
   assign accept     = in_valid_i & en[0];
   assign consume    = v[DEPTH-1] & out_ready_i;

   // Stage registers; an invalid source loads a bubble.
   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         v <= '0;
         for (int k = 0; k < int'(DEPTH); k++) begin
            d[k] <= BUBBLE;
         end
      end else begin
         if (en[0]) begin
            v[0] <= in_valid_i;
            d[0] <= in_valid_i ? in_data_i : BUBBLE;
         end
         for (int k = 1; k < int'(DEPTH); k++) begin
            if (en[k]) begin
               v[k] <= v[k-1];
               d[k] <= v[k-1] ? d[k-1] : BUBBLE;
            end
         end
      end
   end

   // Occupancy tracks accepts and consumes; cleared by flush or reset.
   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         count <= '0;
      end else begin
         count <= count + CW'(accept) - CW'(consume);
      end
   end

   assign out_valid_o = v[DEPTH-1];
   assign out_data_o  = d[DEPTH-1];
   assign count_o     = count;

endmodule

// File: tb/tb_pipe_latch_chain.sv
// Bench for pipe_latch_chain: a DEPTH=3/WIDTH=8 instance with a non-zero
// bubble value and a DEPTH=1/WIDTH=32 instance, both checked every cycle
// against a queue-of-items model where each item carries its stage position.
module tb_pipe_latch_chain;

   typedef struct {
      int          pos;
      logic [31:0] data;
   } item_t;

   localparam logic [7:0] BUB3 = 8'hA5;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // DEPTH=3 instance signals
   logic        rst3, flush3, iv3, ordy3, irdy3, ov3;
   logic [7:0]  id3, od3;
   logic [1:0]  cnt3;
   // DEPTH=1 instance signals
   logic        rst1, flush1, iv1, ordy1, irdy1, ov1;
   logic [31:0] id1, od1;
   logic [0:0]  cnt1;

   pipe_latch_chain #(.WIDTH(8), .DEPTH(3), .BUBBLE(BUB3)) u_dut3 (
      .clk_i(clk), .rst_i(rst3), .flush_i(flush3),
      .in_valid_i(iv3), .in_data_i(id3), .in_ready_o(irdy3),
      .out_valid_o(ov3), .out_data_o(od3), .out_ready_i(ordy3),
      .count_o(cnt3)
   );

   pipe_latch_chain #(.WIDTH(32), .DEPTH(1)) u_dut1 (
      .clk_i(clk), .rst_i(rst1), .flush_i(flush1),
      .in_valid_i(iv1), .in_data_i(id1), .in_ready_o(irdy1),
      .out_valid_o(ov1), .out_data_o(od1), .out_ready_i(ordy1),
      .count_o(cnt1)
   );

   item_t q3[$];
   item_t q1[$];
   int    n_checks = 0;
   int    n_errors = 0;
   int    cyc = 0;
   int    mode1 = 0;
   int    n1 = 0;

   task automatic check_eq(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   // One clock of the item-position model: consume the head if it sits at
   // the last stage, then each item steps forward unless the item ahead
   // (already moved) still occupies the next position.
   task automatic model_step(input bit sel, input int depth, input logic rst,
                             input logic flush, input logic iv,
                             input logic [31:0] din, input logic ordy);
      item_t q[$];
      item_t it;
      int    lim;
      bit    acc;
      if (sel) q = q1; else q = q3;
      if (rst || flush) begin
         q.delete();
      end else begin
         acc = iv && (q.size() < depth || ordy);
         if (q.size() > 0 && q[0].pos == depth - 1 && ordy) void'(q.pop_front());
         for (int i = 0; i < q.size(); i++) begin
            lim = (i == 0) ? depth - 1 : q[i-1].pos - 1;
            if (q[i].pos < lim) q[i].pos = q[i].pos + 1;
         end
         if (acc) begin
            it.pos  = 0;
            it.data = din;
            q.push_back(it);
         end
      end
      if (sel) q1 = q; else q3 = q;
   endtask

   // Drives the DEPTH=1 instance, checks both instances mid-cycle and
   // advances both models on the rising edge.
   task automatic tick();
      bit          v;
      logic [31:0] exp_d;
      if (mode1 == 0) begin
         rst1 = (cyc < 2); flush1 = 1'b0; iv1 = 1'b1;
         ordy1 = cyc[0]; id1 = 32'hDEADBEEF + 32'(n1);
      end else begin
         rst1   = ($urandom_range(0, 39) == 0);
         flush1 = ($urandom_range(0, 19) == 0);
         iv1    = ($urandom_range(0, 3) != 0);
         ordy1  = ($urandom_range(0, 2) != 0);
         id1    = $urandom;
      end
      @(negedge clk);
      v     = (q3.size() > 0 && q3[0].pos == 2);
      exp_d = v ? q3[0].data : 32'(BUB3);
      check_eq("d3_out_valid", 32'(ov3), 32'(v));
      check_eq("d3_out_data", 32'(od3), exp_d);
      check_eq("d3_count", 32'(cnt3), 32'(q3.size()));
      check_eq("d3_in_ready", 32'(irdy3), 32'(q3.size() < 3 || ordy3));
      v     = (q1.size() > 0);
      exp_d = v ? q1[0].data : 32'h0;
      check_eq("d1_out_valid", 32'(ov1), 32'(v));
      check_eq("d1_out_data", od1, exp_d);
      check_eq("d1_count", 32'(cnt1), 32'(q1.size()));
      check_eq("d1_in_ready", 32'(irdy1), 32'(q1.size() < 1 || ordy1));
      @(posedge clk);
      if (!rst1 && !flush1 && iv1 && (q1.size() < 1 || ordy1)) n1++;
      model_step(1'b0, 3, rst3, flush3, iv3, 32'(id3), ordy3);
      model_step(1'b1, 1, rst1, flush1, iv1, id1, ordy1);
      cyc++;
      #1;
   endtask

   task automatic step3(input logic rst, input logic flush, input logic iv,
                        input logic [7:0] din, input logic ordy);
      rst3 = rst; flush3 = flush; iv3 = iv; id3 = din; ordy3 = ordy;
      tick();
   endtask

   initial begin
      rst3 = 1'b1; flush3 = 1'b0; iv3 = 1'b0; id3 = '0; ordy3 = 1'b0;
      rst1 = 1'b1; flush1 = 1'b0; iv1 = 1'b0; id1 = '0; ordy1 = 1'b0;
      #1;
      step3(1, 0, 0, 8'h00, 0);
      step3(1, 0, 0, 8'h00, 0);
      // Streaming at full rate with the output always ready
      step3(0, 0, 1, 8'h11, 1);
      step3(0, 0, 1, 8'h22, 1);
      step3(0, 0, 1, 8'h33, 1);
      repeat (4) step3(0, 0, 0, 8'h00, 1);
      // Backpressure: fill, hold, then simultaneous accept and consume
      step3(0, 0, 1, 8'h0A, 0);
      step3(0, 0, 1, 8'h0B, 0);
      step3(0, 0, 1, 8'h0C, 0);
      step3(0, 0, 1, 8'h0D, 0);
      step3(0, 0, 1, 8'h0D, 1);
      repeat (5) step3(0, 0, 0, 8'h00, 1);
      // Single item collapses through bubbles while stalled
      step3(0, 0, 1, 8'h5C, 0);
      repeat (4) step3(0, 0, 0, 8'h00, 0);
      repeat (2) step3(0, 0, 0, 8'h00, 1);
      // Flush of a full chain drops the concurrent offer
      step3(0, 0, 1, 8'h61, 0);
      step3(0, 0, 1, 8'h62, 0);
      step3(0, 0, 1, 8'h63, 0);
      step3(0, 1, 1, 8'h77, 1);
      repeat (3) step3(0, 0, 0, 8'h00, 1);
      // Reset together with flush and an offer, then a fresh item
      step3(0, 0, 1, 8'h81, 1);
      step3(0, 0, 1, 8'h82, 1);
      step3(1, 1, 1, 8'h99, 1);
      step3(0, 0, 1, 8'h42, 1);
      repeat (4) step3(0, 0, 0, 8'h00, 1);
      // Randomized traffic on both instances
      mode1 = 1;
      repeat (600) begin
         step3(($urandom_range(0, 59) == 0), ($urandom_range(0, 29) == 0),
               ($urandom_range(0, 3) != 0), 8'($urandom),
               ($urandom_range(0, 3) != 0));
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
